// File: rtl/gf_reduce_seq.sv
// gf_reduce_seq: iterative GF(2^m) modular reducer for a carry-less product.
// Removes one product bit position per clock, from bit 2*DATA_WIDTH-1 down to
// bit m, and returns the m-bit remainder.
// Optional build macro GF_RED_EARLY_EXIT_EN: finish as soon as R[k:m] is all zero.
module gf_reduce_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [2*DATA_WIDTH-1:0]       prod_in,
    input  logic [DATA_WIDTH:0]           polyn_red_in,
    input  logic [$clog2(DATA_WIDTH):0]   polyn_grade,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out,
    output logic                          err
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int KW = $clog2(PW);
    localparam int GW = $clog2(DATA_WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [PW-1:0]         r_q, r_d;
    logic [DATA_WIDTH:0]   p_q, p_d;
    logic [GW-1:0]         m_q, m_d;
    logic [KW-1:0]         k_q, k_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  err_q, err_d;

    logic [DATA_WIDTH:0]   poly_mask;
    logic [DATA_WIDTH:0]   poly_lead;
    logic [DATA_WIDTH-1:0] lo_mask;
    logic                  job_bad;
    logic [KW-1:0]         m_k;
    logic [PW-1:0]         p_shift;
    logic [PW-1:0]         r_xor;
    logic                  run_last;
    logic                  done_now;

    // Input qualification: polynomial mask up to x^m, leading-term select, grade check
    always_comb begin
        poly_mask = '0;
        poly_lead = '0;
        for (int i = 0; i <= DATA_WIDTH; i++) begin
            poly_mask[i] = (i <= int'(polyn_grade));
            poly_lead[i] = (i == int'(polyn_grade));
        end
        job_bad = (polyn_grade < GW'(2)) || (polyn_grade > GW'(DATA_WIDTH)) ||
                  !(|(polyn_red_in & poly_lead));
    end

    // Datapath for one reduction step at bit position k
    always_comb begin
        lo_mask = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            lo_mask[i] = (i < int'(m_q));
        end
        m_k      = KW'(m_q);
        p_shift  = {{(DATA_WIDTH-1){1'b0}}, p_q} << (k_q - m_k);
        r_xor    = r_q[k_q] ? (r_q ^ p_shift) : r_q;
        run_last = (k_q == m_k);
`ifdef GF_RED_EARLY_EXIT_EN
        // Bits above k are already cleared, so R >> m == 0 means R[k:m] == 0.
        done_now = run_last || ((r_q >> m_q) == '0);
`else
        done_now = run_last;
`endif
    end

    // Next-state and register-load decisions for IDLE/RUN/DONE
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        p_d     = p_q;
        m_d     = m_q;
        k_d     = k_q;
        out_d   = out_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    r_d = prod_in;
                    m_d = polyn_grade;
                    p_d = polyn_red_in & poly_mask;
                    k_d = '1;
                    if (job_bad) begin
                        state_d = S_DONE;
                        out_d   = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                r_d = r_xor;
                k_d = k_q - 1'b1;
                if (done_now) begin
                    state_d = S_DONE;
                    out_d   = r_xor[DATA_WIDTH-1:0] & lo_mask;
                    err_d   = 1'b0;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset aborts any job in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            p_q     <= '0;
            m_q     <= '0;
            k_q     <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            p_q     <= p_d;
            m_q     <= m_d;
            k_q     <= k_d;
            out_q   <= out_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out       = out_q;
    assign err       = err_q;

endmodule

// File: tb/tb_gf_reduce_seq.sv
// Bench for gf_reduce_seq (DATA_WIDTH=8): directed vectors, backpressure,
// mid-job reset and random jobs checked against polynomial long division.
module tb_gf_reduce_seq;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   prod_in;
    logic [8:0]    polyn_red_in;
    logic [3:0]    polyn_grade;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out;
    logic          err;

    int n_vec = 0;
    int n_err = 0;

    gf_reduce_seq #(.DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .prod_in      (prod_in),
        .polyn_red_in (polyn_red_in),
        .polyn_grade  (polyn_grade),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out          (out),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Remainder of a(x) divided by p(x) over GF(2): cancel the leading term until deg < m.
    function automatic logic [7:0] ref_mod(input logic [15:0] a, input logic [8:0] p, input int m);
        int unsigned r = a;
        int unsigned pp = p;
        int deg;
        forever begin
            deg = -1;
            for (int i = 0; i < 16; i++) if (((r >> i) & 1) != 0) deg = i;
            if (deg < m) break;
            r = r ^ (pp << (deg - m));
        end
        return 8'(r);
    endfunction

    // One job: present at edge 0, count edges to out_valid, hold for 'hold' cycles, then drain.
    task automatic do_job(input logic [15:0] a, input logic [8:0] p, input int m,
                          input int hold, input string tag);
        bit          ok;
        logic [8:0]  pm;
        logic [7:0]  exp_out;
        int          exp_lat;
        int          lat;
        logic [7:0]  seen;
        ok = (m >= 2) && (m <= DW) && (((p >> m) & 9'd1) == 9'd1);
        pm = 9'((32'(p)) & ((32'd1 << (m + 1)) - 1));
        exp_out = ok ? ref_mod(a, pm, m) : 8'h00;
`ifdef GF_RED_EARLY_EXIT_EN
        exp_lat = !ok ? 1 : (((32'(a)) >> m) == 0) ? 2 : -1;
`else
        exp_lat = ok ? (2 * DW - m + 1) : 1;
`endif
        check_eq({tag, "_rdy0"}, in_ready, 1);
        prod_in      = a;
        polyn_red_in = p;
        polyn_grade  = 4'(m);
        in_valid     = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 40);
        check_eq({tag, "_vld"}, out_valid, 1);
        if (exp_lat >= 0) check_eq({tag, "_lat"}, lat, exp_lat);
        else check_eq({tag, "_latrng"}, (lat >= 2 && lat <= 2 * DW - m + 1), 1);
        check_eq({tag, "_out"}, out, exp_out);
        check_eq({tag, "_err"}, err, !ok);
        seen = out;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_eq({tag, "_hold_vld"}, out_valid, 1);
            check_eq({tag, "_hold_out"}, out, seen);
            check_eq({tag, "_hold_rdy"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq({tag, "_drain_vld"}, out_valid, 0);
        check_eq({tag, "_drain_rdy"}, in_ready, 1);
        check_eq({tag, "_keep_out"}, out, seen);
    endtask

    initial begin
        logic [15:0] ra;
        logic [8:0]  rp;
        int          rm;
        rst          = 1'b1;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        prod_in      = '0;
        polyn_red_in = '0;
        polyn_grade  = '0;
        #1;
        check_eq("rst_vld", out_valid, 0);
        check_eq("rst_out", out, 0);
        check_eq("rst_err", err, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_rdy", in_ready, 1);

        // Directed vectors
        do_job(16'h2B79, 9'h11B, 8, 0, "aes");
        check_eq("aes_known", out, 8'hC1);
        do_job(16'h0010, 9'h013, 4, 0, "m4");
        check_eq("m4_known", out, 8'h03);
        do_job(16'h1234, 9'h11B, 1, 0, "m1_bad");
        do_job(16'h1234, 9'h01B, 8, 0, "lead_bad");
        do_job(16'h1234, 9'h11B, 9, 0, "m9_bad");
        do_job(16'h0000, 9'h11B, 8, 0, "zero");
        do_job(16'hFFFF, 9'h007, 2, 0, "m2");
        do_job(16'hA5C3, 9'h11D, 8, 5, "bp");

        // Reset during RUN: outputs clear without a clock edge
        do_job(16'h2B79, 9'h11B, 8, 0, "pre_rst");
        prod_in      = 16'hFFFF;
        polyn_red_in = 9'h11B;
        polyn_grade  = 4'd8;
        in_valid     = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_vld", out_valid, 0);
        check_eq("mid_rst_out", out, 0);
        check_eq("mid_rst_err", err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("post_rst_rdy", in_ready, 1);
        do_job(16'h2B79, 9'h11B, 8, 0, "post_rst");

        // Random jobs, mostly well-formed polynomials
        for (int n = 0; n < 40; n++) begin
            ra = 16'($urandom);
            rm = (n % 8 == 7) ? int'($urandom_range(0, 15)) : int'($urandom_range(2, 8));
            rp = 9'($urandom);
            if ($urandom_range(0, 7) != 0 && rm <= 8) rp = rp | (9'd1 << rm);
            do_job(ra, rp, rm, int'($urandom_range(0, 2)), "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gf_reduce_seq.md
Name: gf_reduce_seq

Overview:
Iterative GF(2^m) modular reducer that sits directly downstream of the carry-less multiplier array.
- Consumes the 2*DATA_WIDTH-bit carry-less product (multiplier mult_out) plus the primitive polynomial and its grade.
- Reduces the product modulo that polynomial one bit position per clock and returns the m-bit field element.
- Has a valid/ready handshake on both sides so it can be chained behind the registered multiplier output.

Parameters:
DATA_WIDTH, 32, maximum field degree; product input is 2*DATA_WIDTH bits, result is DATA_WIDTH bits.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  product/polynomial presented
in_ready  output  1  block can accept a new job
prod_in  input  2*DATA_WIDTH  carry-less product to reduce
polyn_red_in  input  DATA_WIDTH+1  primitive polynomial; bit i = coefficient of x^i
polyn_grade  input  $clog2(DATA_WIDTH)+1  field degree m
out_valid  output  1  result available
out_ready  input  1  downstream accepts result
out  output  DATA_WIDTH  reduced element, bits [m-1:0] valid, upper bits zero
err  output  1  job rejected (invalid grade/polynomial), qualified by out_valid

Behaviour:
- Reset (async, rst=1): state IDLE, in_ready=1 after release, out_valid=0, out=0, err=0, internal regs cleared. Reset mid-job aborts the job with no output.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid & in_ready:
  - latch R=prod_in, m=polyn_grade, P=polyn_red_in masked to bits [m:0].
  - set k=2*DATA_WIDTH-1.
  - go to RUN.
- Invalid job: m<2, m>DATA_WIDTH, or polyn_red_in[m]=0. In that case go straight to DONE with out=0, err=1. The accept cycle still counts, so out_valid rises the next cycle.
- RUN: in_ready=0. Each cycle:
  - if R[k]=1 then R ^= P << (k-m);
  - if k==m go DONE, else k=k-1.
  - Exactly 2*DATA_WIDTH-m RUN cycles.
- On leaving RUN: out register loads R[m-1:0], zero-extended; err=0.
- Latency: input accepted at edge 0 → out_valid=1 after edge 2*DATA_WIDTH-m+1.
- DONE: out_valid=1; out/err held stable until out_ready=1. On out_valid & out_ready go IDLE. Earliest next accept is the following cycle, so there is no same-cycle turnaround.
- out/err keep their last value after handshake until the next job completes; out_valid drops.
- in_valid while not in IDLE is ignored (in_ready=0); no input buffering.
- Input bits of prod_in above 2m-1 are reduced like any other bits (no assumption of a bounded-degree product).
- Counter k width $clog2(2*DATA_WIDTH); no wrap occurs since the loop terminates at k==m≥2.

Optional Feature:
Macro GF_RED_EARLY_EXIT_EN.
- Defined: in each RUN cycle, if R[k:m] are all zero, go to DONE that cycle (result = R[m-1:0]). Latency becomes data-dependent, minimum 1 RUN cycle.
- Undefined: fixed latency of 2*DATA_WIDTH-m RUN cycles regardless of data. Results are identical in both builds.

Test Plan:
- DATA_WIDTH=8, m=8, poly 0x11B, prod_in 0x2B79 (0x57·0x83 carry-less) -> out=0xC1, err=0, out_valid after edge 9 (fixed latency build).
- DATA_WIDTH=8, m=4, poly 0x13, prod_in 0x0010 -> out=0x03, err=0, out_valid after edge 13; out[7:4]=0.
- m=1 (or poly 0x01B with m=8, bit8=0) -> out=0x00, err=1, out_valid after edge 1.
- Backpressure: complete a job with out_ready=0 for 5 cycles -> out_valid held, out stable, in_ready=0. out_ready=1 -> next cycle in_ready=1 and a new job is accepted.
- Assert rst during RUN -> out_valid/out/err go 0 immediately (no clock edge). After release, in_ready=1 and the next job produces the correct result.
- prod_in=0, m=8 -> out=0x00. Without GF_RED_EARLY_EXIT_EN, out_valid after edge 9; with it, out_valid after edge 2.
